// File: rtl/debounce_ctrl.sv
// Debounce sequencer for a single mechanical switch. The raw input is
// synchronised, then an external down-counter is used as a settle timer:
// a level change is committed only after the synchronised input has held
// the new value for the full settle window.
module debounce_ctrl #(
   parameter int             N      = 8,
   parameter logic [N-1:0]   SETTLE = 8'h0A
) (
   input  logic         sysclk,
   input  logic         reset,
   input  logic         sw_i,
   input  logic         cnt_min_tick,
   output logic         cnt_load,
   output logic         cnt_en,
   output logic         cnt_up,
   output logic         cnt_syn_clr,
   output logic [N-1:0] cnt_d,
   output logic         db_level,
   output logic         db_rise,
   output logic         db_fall,
   output logic         busy
);

   // LOADx/WAITx are heading towards level x; IDLEx is settled at level x.
   typedef enum logic [2:0] {
      IDLE0 = 3'd0,
      LOAD1 = 3'd1,
      WAIT1 = 3'd2,
      IDLE1 = 3'd3,
      LOAD0 = 3'd4,
      WAIT0 = 3'd5
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [1:0] r_sync;
   logic       w_sw_s;
   logic       w_load;
   logic       w_en;
   logic       w_clr;
   logic       w_commit_rise;
   logic       w_commit_fall;
   logic       r_level;
   logic       r_rise;
   logic       r_fall;

   assign w_sw_s = r_sync[1];

   // Two-flop synchroniser for the asynchronous switch input.
   always_ff @(posedge sysclk) begin
      if (reset) r_sync <= 2'b00;
      else       r_sync <= {r_sync[0], sw_i};
   end

   // State register.
   always_ff @(posedge sysclk) begin
      if (reset) r_state <= IDLE0;
      else       r_state <= w_next;
   end

   // Next state and counter controls. A mismatch in LOAD/WAIT aborts the
   // window and clears the counter; in WAIT the abort wins over min_tick.
   always_comb begin
      w_next        = r_state;
      w_load        = 1'b0;
      w_en          = 1'b0;
      w_clr         = 1'b0;
      w_commit_rise = 1'b0;
      w_commit_fall = 1'b0;
      case (r_state)
         IDLE0: if (w_sw_s) w_next = LOAD1;
         IDLE1: if (!w_sw_s) w_next = LOAD0;
         LOAD1: begin
            if (w_sw_s) begin
               w_load = 1'b1;
               w_next = WAIT1;
            end else begin
               w_clr  = 1'b1;
               w_next = IDLE0;
            end
         end
         LOAD0: begin
            if (!w_sw_s) begin
               w_load = 1'b1;
               w_next = WAIT0;
            end else begin
               w_clr  = 1'b1;
               w_next = IDLE1;
            end
         end
         WAIT1: begin
            if (!w_sw_s) begin
               w_clr  = 1'b1;
               w_next = IDLE0;
            end else if (cnt_min_tick) begin
               w_commit_rise = 1'b1;
               w_next        = IDLE1;
            end else begin
               w_en = 1'b1;
            end
         end
         WAIT0: begin
            if (w_sw_s) begin
               w_clr  = 1'b1;
               w_next = IDLE1;
            end else if (cnt_min_tick) begin
               w_commit_fall = 1'b1;
               w_next        = IDLE0;
            end else begin
               w_en = 1'b1;
            end
         end
         default: w_next = IDLE0;
      endcase
   end

   // Debounced level and one-cycle edge pulses, registered on commit.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_rise <= w_commit_rise;
         r_fall <= w_commit_fall;
         if (w_commit_rise)      r_level <= 1'b1;
         else if (w_commit_fall) r_level <= 1'b0;
      end
   end

   // Reset holds the counter cleared and idle.
   assign cnt_load    = w_load & ~reset;
   assign cnt_en      = w_en & ~reset;
   assign cnt_syn_clr = w_clr | reset;
   assign cnt_up      = 1'b0;
   assign cnt_d       = SETTLE;

   assign db_level = r_level;
   assign db_rise  = r_rise;
   assign db_fall  = r_fall;
   assign busy     = (r_state == LOAD1) || (r_state == WAIT1) ||
                     (r_state == LOAD0) || (r_state == WAIT0);

endmodule

// File: tb/tb_debounce_ctrl.sv
// Bench for debounce_ctrl with a behavioural N=8 up/down counter wired to
// the cnt_* pins. Table vectors cover reset and a clean rise; hand-written
// sequences cover fall, bounce, abort and reset inside a window.
module tb_debounce_ctrl;

   logic       sysclk;
   logic       reset;
   logic       sw_i;
   logic       cnt_min_tick;
   logic       cnt_load;
   logic       cnt_en;
   logic       cnt_up;
   logic       cnt_syn_clr;
   logic [7:0] cnt_d;
   logic       db_level;
   logic       db_rise;
   logic       db_fall;
   logic       busy;
   logic [7:0] r_q = 8'd0;

   int total = 0;
   int bad   = 0;

   debounce_ctrl #(.N(8), .SETTLE(8'h0A)) dut (
      .sysclk       (sysclk),
      .reset        (reset),
      .sw_i         (sw_i),
      .cnt_min_tick (cnt_min_tick),
      .cnt_load     (cnt_load),
      .cnt_en       (cnt_en),
      .cnt_up       (cnt_up),
      .cnt_syn_clr  (cnt_syn_clr),
      .cnt_d        (cnt_d),
      .db_level     (db_level),
      .db_rise      (db_rise),
      .db_fall      (db_fall),
      .busy         (busy)
   );

   initial begin
      sysclk = 1'b0;
      forever #5 sysclk = ~sysclk;
   end

   // Counter model: clear > load > count.
   always @(posedge sysclk) begin
      if (cnt_syn_clr)  r_q <= 8'd0;
      else if (cnt_load) r_q <= cnt_d;
      else if (cnt_en)   r_q <= cnt_up ? r_q + 8'd1 : r_q - 8'd1;
   end
   assign cnt_min_tick = (r_q == 8'd0);

   typedef struct {
      logic       rst;
      logic       sw;
      logic       lvl;
      logic       rise;
      logic       fall;
      logic       bsy;
      logic       load;
      logic       en;
      logic       clr;
      logic [7:0] q;
   } vec_t;

   vec_t vt[19];

   function automatic vec_t mk(input logic rst, input logic sw, input logic lvl,
                               input logic rise, input logic fall, input logic bsy,
                               input logic load, input logic en, input logic clr,
                               input logic [7:0] q);
      vec_t v;
      v.rst = rst; v.sw = sw; v.lvl = lvl; v.rise = rise; v.fall = fall;
      v.bsy = bsy; v.load = load; v.en = en; v.clr = clr; v.q = q;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge sysclk);
      #1;
   endtask

   // Called just after sw_i changes; expects the edge pulse exactly lat
   // edges later and nothing from either pulse output before that.
   task automatic pulse_after(input bit is_rise, input int lat, input logic lvl);
      for (int k = 1; k <= lat + 1; k++) begin
         tick();
         chk(is_rise ? "rise_pulse" : "fall_pulse", k,
             is_rise ? db_rise : db_fall, (k == lat) ? 1 : 0);
         chk(is_rise ? "fall_quiet" : "rise_quiet", k,
             is_rise ? db_fall : db_rise, 0);
         if (k >= lat) begin
            chk("level_after", k, db_level, lvl);
            chk("busy_after", k, busy, 0);
            chk("q_parked", k, r_q, 0);
         end
      end
   endtask

   initial begin
      int win_cnt;
      int clr_cnt;
      logic prev_busy;

      // Reset, then a clean 0->1: sw_s rises at vector 4, commit at 17.
      vt[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 8'd0);
      vt[1] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 8'd0);
      vt[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
      vt[3] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 8'd0);
      vt[4] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 8'd0);
      vt[5] = mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 8'd0);
      for (int i = 6; i <= 15; i++)
         vt[i] = mk(0, 1, 0, 0, 0, 1, 0, 1, 0, 8'(16 - i));
      vt[16] = mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 8'd0);
      vt[17] = mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 8'd0);
      vt[18] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 8'd0);

      reset = 1'b1;
      sw_i  = 1'b0;
      for (int i = 0; i < 19; i++) begin
         reset = vt[i].rst;
         sw_i  = vt[i].sw;
         tick();
         chk("db_level", i, db_level, vt[i].lvl);
         chk("db_rise", i, db_rise, vt[i].rise);
         chk("db_fall", i, db_fall, vt[i].fall);
         chk("busy", i, busy, vt[i].bsy);
         chk("cnt_load", i, cnt_load, vt[i].load);
         chk("cnt_en", i, cnt_en, vt[i].en);
         chk("cnt_syn_clr", i, cnt_syn_clr, vt[i].clr);
         chk("q", i, r_q, vt[i].q);
         chk("cnt_up", i, cnt_up, 0);
         chk("cnt_d", i, cnt_d, 8'h0A);
      end

      // Clean 1->0 from the settled high level.
      sw_i = 1'b0;
      pulse_after(1'b0, 15, 1'b0);

      // Sub-period bounce ending low: every window must abort with a clear.
      win_cnt   = 0;
      clr_cnt   = 0;
      prev_busy = busy;
      fork
         begin
            repeat (20) begin
               #2 sw_i = ~sw_i;
            end
         end
         begin
            for (int k = 0; k < 15; k++) begin
               tick();
               if (busy && !prev_busy) win_cnt++;
               if (cnt_syn_clr) clr_cnt++;
               chk("bounce_no_rise", k, db_rise, 0);
               prev_busy = busy;
            end
         end
      join
      chk("bounce_sw_end", 0, sw_i, 0);
      chk("bounce_opened", 0, (win_cnt >= 1) ? 1 : 0, 1);
      chk("bounce_clr_per_win", 0, clr_cnt, win_cnt);
      chk("bounce_level", 0, db_level, 0);
      chk("bounce_idle", 0, busy, 0);

      // Short high pulse: window opens and aborts in WAIT1.
      sw_i = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("short_no_rise", k, db_rise, 0);
      end
      sw_i = 1'b0;
      tick();
      chk("short_wait_en", 0, cnt_en, 1);
      chk("short_wait_busy", 0, busy, 1);
      tick();
      chk("short_abort_clr", 0, cnt_syn_clr, 1);
      chk("short_abort_en", 0, cnt_en, 0);
      chk("short_abort_load", 0, cnt_load, 0);
      tick();
      chk("short_idle", 0, busy, 0);
      chk("short_level", 0, db_level, 0);
      chk("short_no_rise2", 0, db_rise, 0);
      chk("short_q_clr", 0, r_q, 0);
      // Then held high: full commit.
      sw_i = 1'b1;
      pulse_after(1'b1, 15, 1'b1);

      // Back to low, then reset in the middle of a rising window.
      sw_i = 1'b0;
      pulse_after(1'b0, 15, 1'b0);
      sw_i = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("mid_no_rise", k, db_rise, 0);
      end
      chk("mid_q", 0, r_q, 4);
      chk("mid_busy", 0, busy, 1);
      reset = 1'b1;
      tick();
      chk("rst_mid_busy", 0, busy, 0);
      chk("rst_mid_level", 0, db_level, 0);
      chk("rst_mid_rise", 0, db_rise, 0);
      chk("rst_mid_q", 0, r_q, 0);
      chk("rst_mid_clr", 0, cnt_syn_clr, 1);
      reset = 1'b0;
      pulse_after(1'b1, 15, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
